// File: rtl/count_checker.sv
// count_checker: watches a 4-bit down counter, locks onto a clean decrement
// sequence, then flags sequence errors (saturating count) and stalls.
module count_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 100000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  input  logic       clr,
  output logic       locked,
  output logic       err,
  output logic       stall,
  output logic [7:0] err_count,
  output logic [3:0] last_value
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t       r_state, w_next;
  logic [3:0]   r_s1, r_s2, r_s3;
  logic [RW-1:0] r_run, w_run;
  logic [31:0]  r_tmr, w_tmr;
  logic [7:0]   r_errc;
  logic [3:0]   r_last;
  logic         r_err, r_stall;
  logic         w_chg, w_good, w_tout, w_err, w_inc, w_stall_set;
  assign w_chg  = r_s2 != r_s3;
  // 4-bit compare makes 0 -> 15 a correct step and 15 -> 0 an error
  assign w_good = r_s2 == r_s3 - 4'd1;
  assign w_tout = r_tmr + 32'd1 == 32'(TIMEOUT);
  always_comb begin
    w_next      = r_state;
    w_run       = r_run;
    w_tmr       = '0;
    w_err       = 1'b0;
    w_inc       = 1'b0;
    w_stall_set = 1'b0;
    if (r_state == SEARCH) begin
      if (w_chg) begin
        if (!w_good) w_run = '0;
        else if (r_run == RW'(LOCK_COUNT - 1)) begin
          w_next = LOCKED;
          w_run  = '0;
        end else w_run = r_run + RW'(1);
      end
    end else if (w_chg) begin
      if (!w_good) begin
        w_err  = 1'b1;
        w_inc  = 1'b1;
        w_next = SEARCH;
        w_run  = '0;
      end
    end else if (w_tout) begin
      w_stall_set = 1'b1;
      w_next      = SEARCH;
    end else w_tmr = r_tmr + 32'd1;
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= SEARCH;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_run   <= '0;
      r_tmr   <= '0;
      r_errc  <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_s1    <= cnt_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_next;
      r_run   <= w_run;
      r_tmr   <= w_tmr;
      r_err   <= w_err;
      r_last  <= r_s2;
      r_errc  <= clr ? 8'd0 : (w_inc && r_errc != 8'hff) ? r_errc + 8'd1 : r_errc;
      r_stall <= clr ? 1'b0 : r_stall | w_stall_set;
    end
  end
  assign locked     = r_state == LOCKED;
  assign err        = r_err;
  assign stall      = r_stall;
  assign err_count  = r_errc;
  assign last_value = r_last;
endmodule
